wishbone_arbiter: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter that shares the memory bus between the core (master 0) and a secondary master (master 1, DMA/debug).
- Grants ownership round-robin, holds the grant for the whole CYC of the owner, and forwards the owner's signals to the slave.
- A watchdog ends any access that the slave does not ACK within TIMEOUT cycles and returns ERR to the owner, so a dead slave cannot hang the core.

---
 rtl/wishbone_arbiter.sv | 130 +++++++++++++
 tb/tb_wishbone_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter: round-robin grant held for the
// owner's whole CYC, combinational forwarding, and an ACK watchdog that answers with ERR.
module wishbone_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   m0_CYC_I,
  input  logic                   m0_STB_I,
  input  logic                   m0_WE_I,
  input  logic [DATA_SIZE/8-1:0] m0_SEL_I,
  input  logic [DATA_SIZE-1:0]   m0_ADR_I,
  input  logic [DATA_SIZE-1:0]   m0_DAT_I,
  output logic [DATA_SIZE-1:0]   m0_DAT_O,
  output logic                   m0_ACK_O,
  output logic                   m0_ERR_O,
  input  logic                   m1_CYC_I,
  input  logic                   m1_STB_I,
  input  logic                   m1_WE_I,
  input  logic [DATA_SIZE/8-1:0] m1_SEL_I,
  input  logic [DATA_SIZE-1:0]   m1_ADR_I,
  input  logic [DATA_SIZE-1:0]   m1_DAT_I,
  output logic [DATA_SIZE-1:0]   m1_DAT_O,
  output logic                   m1_ACK_O,
  output logic                   m1_ERR_O,
  output logic                   s_CYC_O,
  output logic                   s_STB_O,
  output logic                   s_WE_O,
  output logic [DATA_SIZE/8-1:0] s_SEL_O,
  output logic [DATA_SIZE-1:0]   s_ADR_O,
  output logic [DATA_SIZE-1:0]   s_DAT_O,
  input  logic [DATA_SIZE-1:0]   s_DAT_I,
  input  logic                   s_ACK_I,
  output logic [1:0]             grant,
  output logic [1:0]             fsm_state
);

  // Handshake: a beat completes on the edge where STB and ACK (or ERR) are both high;
  // the owner keeps the bus for as long as its CYC stays high.
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam int SW = DATA_SIZE / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state, state_next;
  logic            last_owner;
  logic [CW-1:0]   cnt;
  logic            timed_out;
  logic            owned, timeout_hit, ack_ok;
  logic            own_cyc, own_stb, own_we;
  logic [SW-1:0]   own_sel;
  logic [DATA_SIZE-1:0] own_adr, own_dat;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    case (state)
      OWN0: begin
        own_cyc = m0_CYC_I; own_stb = m0_STB_I; own_we = m0_WE_I;
        own_sel = m0_SEL_I; own_adr = m0_ADR_I; own_dat = m0_DAT_I;
      end
      OWN1: begin
        own_cyc = m1_CYC_I; own_stb = m1_STB_I; own_we = m1_WE_I;
        own_sel = m1_SEL_I; own_adr = m1_ADR_I; own_dat = m1_DAT_I;
      end
      default: ;
    endcase
  end

  assign owned       = (state != IDLE);
  // ACK in the same cycle as the limit wins, so no ERR is raised then.
  assign timeout_hit = (TIMEOUT > 0) && owned && own_stb && !s_ACK_I && !timed_out &&
                       (cnt == CW'(TIMEOUT));
  assign ack_ok      = owned && s_ACK_I && !timed_out;

  assign s_CYC_O  = own_cyc && !timed_out;
  assign s_STB_O  = own_stb && !timed_out;
  assign s_WE_O   = own_we;
  assign s_SEL_O  = own_sel;
  assign s_ADR_O  = own_adr;
  assign s_DAT_O  = own_dat;
  assign m0_DAT_O = s_DAT_I;
  assign m1_DAT_O = s_DAT_I;
  assign m0_ACK_O = ack_ok && (state == OWN0);
  assign m1_ACK_O = ack_ok && (state == OWN1);
  assign m0_ERR_O = timeout_hit && (state == OWN0);
  assign m1_ERR_O = timeout_hit && (state == OWN1);
  assign grant     = {state == OWN1, state == OWN0};
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_CYC_I && m1_CYC_I) state_next = last_owner ? OWN0 : OWN1;
        else if (m0_CYC_I)        state_next = OWN0;
        else if (m1_CYC_I)        state_next = OWN1;
      end
      OWN0, OWN1: if (!own_cyc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= '0;
      timed_out  <= 1'b0;
    end else begin
      state <= state_next;
      if (!owned || !own_cyc) begin
        cnt       <= '0;
        timed_out <= 1'b0;
        if (owned) last_owner <= (state == OWN1);
      end else begin
        if (timeout_hit) timed_out <= 1'b1;
        // Counter saturates at TIMEOUT; it is frozen once timed_out is set.
        if (s_ACK_I || !own_stb) cnt <= '0;
        else if ((TIMEOUT > 0) && !timed_out && (cnt != CW'(TIMEOUT))) cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter (TIMEOUT=4): arbitration, handover, watchdog, reset.
module tb_wishbone_arbiter;

  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic m0_CYC_I, m0_STB_I, m0_WE_I, m1_CYC_I, m1_STB_I, m1_WE_I;
  logic [DW/8-1:0] m0_SEL_I, m1_SEL_I, s_SEL_O;
  logic [DW-1:0] m0_ADR_I, m0_DAT_I, m1_ADR_I, m1_DAT_I, m0_DAT_O, m1_DAT_O;
  logic [DW-1:0] s_ADR_O, s_DAT_O, s_DAT_I;
  logic m0_ACK_O, m0_ERR_O, m1_ACK_O, m1_ERR_O, s_CYC_O, s_STB_O, s_WE_O, s_ACK_I;
  logic [1:0] grant, fsm_state;

  int checks_total = 0;
  int checks_passed = 0;

  wishbone_arbiter #(.DATA_SIZE(DW), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I), .m0_WE_I(m0_WE_I), .m0_SEL_I(m0_SEL_I),
    .m0_ADR_I(m0_ADR_I), .m0_DAT_I(m0_DAT_I), .m0_DAT_O(m0_DAT_O),
    .m0_ACK_O(m0_ACK_O), .m0_ERR_O(m0_ERR_O),
    .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I), .m1_WE_I(m1_WE_I), .m1_SEL_I(m1_SEL_I),
    .m1_ADR_I(m1_ADR_I), .m1_DAT_I(m1_DAT_I), .m1_DAT_O(m1_DAT_O),
    .m1_ACK_O(m1_ACK_O), .m1_ERR_O(m1_ERR_O),
    .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O), .s_SEL_O(s_SEL_O),
    .s_ADR_O(s_ADR_O), .s_DAT_O(s_DAT_O), .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I),
    .grant(grant), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    m0_CYC_I = 0; m0_STB_I = 0; m0_WE_I = 0; m0_SEL_I = '0; m0_ADR_I = '0; m0_DAT_I = '0;
    m1_CYC_I = 0; m1_STB_I = 0; m1_WE_I = 0; m1_SEL_I = '0; m1_ADR_I = '0; m1_DAT_I = '0;
    s_ACK_I = 0; s_DAT_I = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    checks_total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else checks_passed++;
    checks_total++; if (fsm_state !== 2'b00) $display("FAIL reset_state: got %b want 00", fsm_state); else checks_passed++;
    checks_total++; if ({s_CYC_O, s_STB_O, m0_ACK_O, m0_ERR_O, m1_ACK_O, m1_ERR_O} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000", {s_CYC_O, s_STB_O, m0_ACK_O, m0_ERR_O, m1_ACK_O, m1_ERR_O});
    else checks_passed++;
  endtask

  task automatic test_m0_read();
    step(); m0_CYC_I = 1; m0_STB_I = 1; m0_ADR_I = 32'h100;
    @(negedge clock);
    checks_total++; if (grant !== 2'b00) $display("FAIL rd_latency_grant: got %b want 00", grant); else checks_passed++;
    checks_total++; if (s_CYC_O !== 1'b0) $display("FAIL rd_idle_cyc: got %b want 0", s_CYC_O); else checks_passed++;
    step();
    @(negedge clock);
    checks_total++; if (grant !== 2'b01) $display("FAIL rd_grant: got %b want 01", grant); else checks_passed++;
    checks_total++; if (s_ADR_O !== 32'h100) $display("FAIL rd_adr: got %h want 00000100", s_ADR_O); else checks_passed++;
    checks_total++; if (m0_ACK_O !== 1'b0) $display("FAIL rd_early_ack: got %b want 0", m0_ACK_O); else checks_passed++;
    step(); s_ACK_I = 1; s_DAT_I = 32'hDEADBEEF;
    @(negedge clock);
    checks_total++; if (m0_ACK_O !== 1'b1) $display("FAIL rd_ack: got %b want 1", m0_ACK_O); else checks_passed++;
    checks_total++; if (m0_DAT_O !== 32'hDEADBEEF) $display("FAIL rd_dat: got %h want deadbeef", m0_DAT_O); else checks_passed++;
    checks_total++; if (m1_ACK_O !== 1'b0) $display("FAIL rd_m1_ack: got %b want 0", m1_ACK_O); else checks_passed++;
    step(); s_ACK_I = 0; m0_CYC_I = 0; m0_STB_I = 0;
    @(negedge clock);
    checks_total++; if (m0_ACK_O !== 1'b0) $display("FAIL rd_ack_single: got %b want 0", m0_ACK_O); else checks_passed++;
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [11];
    exp_g = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      step();
      case (c)
        0:  begin m0_CYC_I = 1; m1_CYC_I = 1; end
        2:  m0_CYC_I = 0;
        4:  m0_CYC_I = 1;
        5:  m1_CYC_I = 0;
        8:  begin m0_CYC_I = 0; m1_CYC_I = 1; end
        default: ;
      endcase
      @(negedge clock);
      checks_total++;
      if (grant !== exp_g[c]) $display("FAIL rr_grant_c%0d: got %b want %b", c, grant, exp_g[c]);
      else checks_passed++;
      checks_total++;
      if (grant === 2'b11) $display("FAIL rr_onehot_c%0d: got %b want not 11", c, grant);
      else checks_passed++;
    end
    step(); idle_inputs();
    step(); step();
  endtask

  task automatic test_m1_write();
    apply_reset();
    step(); m1_CYC_I = 1; m1_STB_I = 1; m1_WE_I = 1; m1_SEL_I = 4'b0001;
    m1_DAT_I = 32'h0000_00A5; m1_ADR_I = 32'h200;
    @(negedge clock);
    checks_total++; if (grant !== 2'b00) $display("FAIL wr_latency: got %b want 00", grant); else checks_passed++;
    step(); m0_CYC_I = 1; m0_STB_I = 1; m0_ADR_I = 32'h300; m0_DAT_I = 32'hFFFF_FFFF; m0_SEL_I = 4'b1111;
    @(negedge clock);
    checks_total++; if (grant !== 2'b10) $display("FAIL wr_grant: got %b want 10", grant); else checks_passed++;
    checks_total++; if ({s_WE_O, s_SEL_O} !== 5'b1_0001) $display("FAIL wr_we_sel: got %b want 10001", {s_WE_O, s_SEL_O}); else checks_passed++;
    checks_total++; if (s_DAT_O !== 32'hA5) $display("FAIL wr_dat: got %h want 000000a5", s_DAT_O); else checks_passed++;
    checks_total++; if (s_ADR_O !== 32'h200) $display("FAIL wr_adr: got %h want 00000200", s_ADR_O); else checks_passed++;
    step(); s_ACK_I = 1;
    @(negedge clock);
    checks_total++; if ({m1_ACK_O, m0_ACK_O} !== 2'b10) $display("FAIL wr_ack: got %b want 10", {m1_ACK_O, m0_ACK_O}); else checks_passed++;
    step(); s_ACK_I = 0; m1_CYC_I = 0; m1_STB_I = 0; m1_WE_I = 0;
    @(negedge clock);
    checks_total++; if (grant !== 2'b10) $display("FAIL wr_drop_grant: got %b want 10", grant); else checks_passed++;
    step();
    @(negedge clock);
    checks_total++; if ({grant, s_CYC_O} !== 3'b000) $display("FAIL wr_dead_cycle: got %b want 000", {grant, s_CYC_O}); else checks_passed++;
    step();
    @(negedge clock);
    checks_total++; if (grant !== 2'b01) $display("FAIL wr_handover: got %b want 01", grant); else checks_passed++;
    checks_total++; if (s_ADR_O !== 32'h300) $display("FAIL wr_handover_adr: got %h want 00000300", s_ADR_O); else checks_passed++;
    step(); idle_inputs();
    step();
  endtask

  task automatic test_timeout();
    apply_reset();
    step(); m0_CYC_I = 1; m0_STB_I = 1; m0_ADR_I = 32'h400;
    step();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      checks_total++; if (m0_ERR_O !== 1'b0) $display("FAIL to_early_err_%0d: got %b want 0", i, m0_ERR_O); else checks_passed++;
      step();
    end
    @(negedge clock);
    checks_total++; if ({m0_ERR_O, m0_ACK_O} !== 2'b10) $display("FAIL to_err: got %b want 10", {m0_ERR_O, m0_ACK_O}); else checks_passed++;
    checks_total++; if (s_CYC_O !== 1'b1) $display("FAIL to_cyc_before: got %b want 1", s_CYC_O); else checks_passed++;
    step(); s_ACK_I = 1;
    @(negedge clock);
    checks_total++; if ({s_CYC_O, s_STB_O} !== 2'b00) $display("FAIL to_forced: got %b want 00", {s_CYC_O, s_STB_O}); else checks_passed++;
    checks_total++; if ({m0_ERR_O, m0_ACK_O} !== 2'b00) $display("FAIL to_quiet: got %b want 00", {m0_ERR_O, m0_ACK_O}); else checks_passed++;
    checks_total++; if (grant !== 2'b01) $display("FAIL to_hold: got %b want 01", grant); else checks_passed++;
    step(); s_ACK_I = 0; m0_CYC_I = 0; m0_STB_I = 0;
    @(negedge clock);
    checks_total++; if (grant !== 2'b01) $display("FAIL to_drop: got %b want 01", grant); else checks_passed++;
    step();
    @(negedge clock);
    checks_total++; if (grant !== 2'b00) $display("FAIL to_release: got %b want 00", grant); else checks_passed++;
  endtask

  task automatic test_ack_at_timeout();
    apply_reset();
    step(); m0_CYC_I = 1; m0_STB_I = 1;
    step();
    repeat (4) step();
    s_ACK_I = 1; s_DAT_I = 32'h1234_5678;
    @(negedge clock);
    checks_total++; if ({m0_ACK_O, m0_ERR_O} !== 2'b10) $display("FAIL ack_wins: got %b want 10", {m0_ACK_O, m0_ERR_O}); else checks_passed++;
    checks_total++; if (m0_DAT_O !== 32'h1234_5678) $display("FAIL ack_wins_dat: got %h want 12345678", m0_DAT_O); else checks_passed++;
    step(); s_ACK_I = 0; m0_STB_I = 0;
    @(negedge clock);
    checks_total++; if ({s_CYC_O, m0_ERR_O} !== 2'b10) $display("FAIL ack_no_lockout: got %b want 10", {s_CYC_O, m0_ERR_O}); else checks_passed++;
    step(); m0_CYC_I = 0;
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step(); m0_CYC_I = 1; m0_STB_I = 1;
    step();
    step(); s_ACK_I = 1;
    #1;
    checks_total++; if (m0_ACK_O !== 1'b1) $display("FAIL rm_ack_before: got %b want 1", m0_ACK_O); else checks_passed++;
    #1 reset = 1'b0;
    #1;
    checks_total++; if ({s_CYC_O, s_STB_O} !== 2'b00) $display("FAIL rm_slave: got %b want 00", {s_CYC_O, s_STB_O}); else checks_passed++;
    checks_total++; if (grant !== 2'b00) $display("FAIL rm_grant: got %b want 00", grant); else checks_passed++;
    checks_total++; if ({m0_ACK_O, m0_ERR_O, m1_ACK_O, m1_ERR_O} !== 4'b0) $display("FAIL rm_ackerr: got %b want 0000", {m0_ACK_O, m0_ERR_O, m1_ACK_O, m1_ERR_O}); else checks_passed++;
    s_ACK_I = 0; m0_STB_I = 0; m1_CYC_I = 1;
    @(negedge clock);
    reset = 1'b1;
    step();
    checks_total++; if (grant !== 2'b01) $display("FAIL rm_tie_after: got %b want 01", grant); else checks_passed++;
    idle_inputs();
    step(); step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_m0_read();
    test_round_robin();
    test_m1_write();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
